// File: rtl/subtractor_result_monitor.sv
// Purpose: windowed observer of the subtractor result stream (first/last/min/max/wrap count).
// Latency: report valid the cycle after the final sample edge (WINDOW-1 edges after start).
// Backpressure: report held stable in REPORT until rpt_ready; no new window starts meanwhile.
module subtractor_result_monitor #(
   parameter int WINDOW = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] result,
   output logic       busy,
   output logic       rpt_valid,
   input  logic       rpt_ready,
   output logic [7:0] rpt_first,
   output logic [7:0] rpt_last,
   output logic [7:0] rpt_min,
   output logic [7:0] rpt_max,
   output logic [7:0] rpt_wraps
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_REPORT = 2'd2
   } state_t;

   // Index of the final sample; cnt holds the index of the sample captured next.
   localparam logic [7:0] LAST_IDX = 8'(WINDOW - 1);

   state_t     state_q, state_d;
   logic       busy_q, busy_d;
   logic       rpt_valid_q, rpt_valid_d;

   logic [7:0] first_q, first_d;
   logic [7:0] last_q, last_d;
   logic [7:0] min_q, min_d;
   logic [7:0] max_q, max_d;
   logic [7:0] prev_q, prev_d;
   logic [7:0] wraps_q, wraps_d;
   logic [7:0] cnt_q, cnt_d;

   logic [7:0] rpt_first_q, rpt_first_d;
   logic [7:0] rpt_last_q, rpt_last_d;
   logic [7:0] rpt_min_q, rpt_min_d;
   logic [7:0] rpt_max_q, rpt_max_d;
   logic [7:0] rpt_wraps_q, rpt_wraps_d;

   logic       accept_start;
   logic       run_step;
   logic       final_sample;
   logic       wrap_evt;
   logic [7:0] run_min;
   logic [7:0] run_max;
   logic [7:0] run_wraps;

   assign accept_start = (state_q == S_IDLE) && start && !abort;
   assign run_step     = (state_q == S_RUN) && !abort;
   assign final_sample = (cnt_q == LAST_IDX);

   // An upward step of a decreasing difference means it underflowed past zero.
   assign wrap_evt  = (result > prev_q);
   assign run_min   = (result < min_q) ? result : min_q;
   assign run_max   = (result > max_q) ? result : max_q;
   assign run_wraps = wraps_q + {7'd0, wrap_evt};

   // State register plus registered outputs derived from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         rpt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         rpt_valid_q <= rpt_valid_d;
      end
   end

   // Next-state logic; abort beats both start and the final-sample transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) state_d = S_RUN;
         end
         S_RUN: begin
            if (abort)             state_d = S_IDLE;
            else if (final_sample) state_d = S_REPORT;
         end
         S_REPORT: begin
            if (abort)          state_d = S_IDLE;
            else if (rpt_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the next state so busy/rpt_valid come straight from flops.
   always_comb begin
      busy_d      = (state_d == S_RUN);
      rpt_valid_d = (state_d == S_REPORT);
   end

   // Window accumulators and report fields; the report loads on the final capture edge.
   always_comb begin
      first_d     = first_q;
      last_d      = last_q;
      min_d       = min_q;
      max_d       = max_q;
      prev_d      = prev_q;
      wraps_d     = wraps_q;
      cnt_d       = cnt_q;
      rpt_first_d = rpt_first_q;
      rpt_last_d  = rpt_last_q;
      rpt_min_d   = rpt_min_q;
      rpt_max_d   = rpt_max_q;
      rpt_wraps_d = rpt_wraps_q;
      if (accept_start) begin
         first_d = result;
         last_d  = result;
         min_d   = result;
         max_d   = result;
         prev_d  = result;
         wraps_d = 8'd0;
         cnt_d   = 8'd1;
      end else if (run_step) begin
         last_d  = result;
         prev_d  = result;
         min_d   = run_min;
         max_d   = run_max;
         wraps_d = run_wraps;
         cnt_d   = cnt_q + 8'd1;
         if (final_sample) begin
            rpt_first_d = first_q;
            rpt_last_d  = result;
            rpt_min_d   = run_min;
            rpt_max_d   = run_max;
            rpt_wraps_d = run_wraps;
         end
      end
   end

   // Datapath registers; reset clears everything including cnt and prev.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         first_q     <= 8'd0;
         last_q      <= 8'd0;
         min_q       <= 8'd0;
         max_q       <= 8'd0;
         prev_q      <= 8'd0;
         wraps_q     <= 8'd0;
         cnt_q       <= 8'd0;
         rpt_first_q <= 8'd0;
         rpt_last_q  <= 8'd0;
         rpt_min_q   <= 8'd0;
         rpt_max_q   <= 8'd0;
         rpt_wraps_q <= 8'd0;
      end else begin
         first_q     <= first_d;
         last_q      <= last_d;
         min_q       <= min_d;
         max_q       <= max_d;
         prev_q      <= prev_d;
         wraps_q     <= wraps_d;
         cnt_q       <= cnt_d;
         rpt_first_q <= rpt_first_d;
         rpt_last_q  <= rpt_last_d;
         rpt_min_q   <= rpt_min_d;
         rpt_max_q   <= rpt_max_d;
         rpt_wraps_q <= rpt_wraps_d;
      end
   end

   assign busy      = busy_q;
   assign rpt_valid = rpt_valid_q;
   assign rpt_first = rpt_first_q;
   assign rpt_last  = rpt_last_q;
   assign rpt_min   = rpt_min_q;
   assign rpt_max   = rpt_max_q;
   assign rpt_wraps = rpt_wraps_q;

endmodule

// File: tb/tb_subtractor_result_monitor.sv
// Bench for subtractor_result_monitor: WINDOW=4 and WINDOW=8 instances on one clock.
// Table-driven windows plus hand-written abort, priority, constant and reset sequences.
// Inputs change 1 ns after the rising edge; outputs are compared at that same point.
module tb_subtractor_result_monitor;

   logic       clk;
   logic       rst;
   logic       start4, start8;
   logic       abort;
   logic [7:0] result;
   logic       rpt_ready;

   logic       busy4, valid4, busy8, valid8;
   logic [7:0] first4, last4, min4, max4, wraps4;
   logic [7:0] first8, last8, min8, max8, wraps8;

   int passed = 0;
   int total  = 0;

   subtractor_result_monitor #(.WINDOW(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .start     (start4),
      .abort     (abort),
      .result    (result),
      .busy      (busy4),
      .rpt_valid (valid4),
      .rpt_ready (rpt_ready),
      .rpt_first (first4),
      .rpt_last  (last4),
      .rpt_min   (min4),
      .rpt_max   (max4),
      .rpt_wraps (wraps4)
   );

   subtractor_result_monitor #(.WINDOW(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .start     (start8),
      .abort     (abort),
      .result    (result),
      .busy      (busy8),
      .rpt_valid (valid8),
      .rpt_ready (rpt_ready),
      .rpt_first (first8),
      .rpt_last  (last8),
      .rpt_min   (min8),
      .rpt_max   (max8),
      .rpt_wraps (wraps8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [0:3][7:0] s;
      logic [7:0]      first;
      logic [7:0]      last;
      logic [7:0]      mn;
      logic [7:0]      mx;
      logic [7:0]      wraps;
   } vec_t;

   vec_t vecs [3];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{s: {8'd100, 8'd95, 8'd90, 8'd85},  first: 8'd100, last: 8'd85,  mn: 8'd85, mx: 8'd100, wraps: 8'd0};
      vecs[1] = '{s: {8'd10,  8'd5,  8'd0,  8'd251}, first: 8'd10,  last: 8'd251, mn: 8'd0,  mx: 8'd251, wraps: 8'd1};
      vecs[2] = '{s: {8'd3,   8'd254, 8'd249, 8'd244}, first: 8'd3, last: 8'd244, mn: 8'd3,  mx: 8'd254, wraps: 8'd1};

      rst = 1'b0; start4 = 1'b0; start8 = 1'b0; abort = 1'b0; result = 8'd0; rpt_ready = 1'b0;
      #2;
      check("reset busy", {7'd0, busy4}, 8'd0);
      check("reset valid", {7'd0, valid4}, 8'd0);
      check("reset first", first4, 8'd0);
      tick();
      #4 rst = 1'b1;
      tick();
      check("idle busy after release", {7'd0, busy4}, 8'd0);

      // Table-driven windows on the WINDOW=4 instance.
      for (int i = 0; i < 3; i++) begin
         rpt_ready = (i == 2);
         start4 = 1'b1;
         result = vecs[i].s[0];
         tick();
         start4 = 1'b0;
         check($sformatf("v%0d busy after E0", i), {7'd0, busy4}, 8'd1);
         for (int k = 1; k < 4; k++) begin
            result = vecs[i].s[k];
            tick();
            if (k < 3) begin
               check($sformatf("v%0d busy after E%0d", i, k), {7'd0, busy4}, 8'd1);
               check($sformatf("v%0d no valid E%0d", i, k), {7'd0, valid4}, 8'd0);
            end
         end
         check($sformatf("v%0d busy falls", i), {7'd0, busy4}, 8'd0);
         check($sformatf("v%0d valid", i), {7'd0, valid4}, 8'd1);
         check($sformatf("v%0d first", i), first4, vecs[i].first);
         check($sformatf("v%0d last", i), last4, vecs[i].last);
         check($sformatf("v%0d min", i), min4, vecs[i].mn);
         check($sformatf("v%0d max", i), max4, vecs[i].mx);
         check($sformatf("v%0d wraps", i), wraps4, vecs[i].wraps);
         if (i == 0) begin
            for (int c = 0; c < 5; c++) begin
               tick();
               check($sformatf("bp valid c%0d", c), {7'd0, valid4}, 8'd1);
               check($sformatf("bp first c%0d", c), first4, vecs[0].first);
               check($sformatf("bp last c%0d", c), last4, vecs[0].last);
               check($sformatf("bp min c%0d", c), min4, vecs[0].mn);
            end
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            check("start ignored in report", {7'd0, busy4}, 8'd0);
            check("report still valid", {7'd0, valid4}, 8'd1);
         end
         rpt_ready = 1'b1;
         tick();
         rpt_ready = 1'b0;
         check($sformatf("v%0d valid drops", i), {7'd0, valid4}, 8'd0);
         check($sformatf("v%0d fields kept", i), max4, vecs[i].mx);
      end

      // Abort on the third sample edge: window discarded, old report kept.
      start4 = 1'b1; result = 8'd50; tick();
      start4 = 1'b0; result = 8'd60; tick();
      abort = 1'b1;  result = 8'd70; tick();
      abort = 1'b0;
      check("abort E2 busy", {7'd0, busy4}, 8'd0);
      check("abort E2 valid", {7'd0, valid4}, 8'd0);
      result = 8'd80; tick();
      check("abort E2 valid later", {7'd0, valid4}, 8'd0);
      check("abort E2 first kept", first4, 8'd3);
      check("abort E2 last kept", last4, 8'd244);
      check("abort E2 wraps kept", wraps4, 8'd1);

      // Abort on the final sample edge wins over the report.
      start4 = 1'b1; result = 8'd50; tick();
      start4 = 1'b0; result = 8'd60; tick();
      result = 8'd70; tick();
      abort = 1'b1; result = 8'd80; tick();
      abort = 1'b0;
      check("abort final busy", {7'd0, busy4}, 8'd0);
      check("abort final valid", {7'd0, valid4}, 8'd0);
      tick();
      check("abort final valid later", {7'd0, valid4}, 8'd0);
      check("abort final min kept", min4, 8'd3);

      // start and abort together in IDLE.
      start4 = 1'b1; abort = 1'b1; tick();
      start4 = 1'b0; abort = 1'b0;
      check("start+abort busy", {7'd0, busy4}, 8'd0);
      tick();
      check("start+abort busy later", {7'd0, busy4}, 8'd0);

      // Constant input on the WINDOW=8 instance: equal samples are not wraps.
      start8 = 1'b1; result = 8'd7; tick();
      start8 = 1'b0;
      for (int k = 1; k < 8; k++) begin
         check($sformatf("w8 busy before E%0d", k), {7'd0, busy8}, 8'd1);
         tick();
      end
      check("w8 busy falls", {7'd0, busy8}, 8'd0);
      check("w8 valid", {7'd0, valid8}, 8'd1);
      check("w8 first", first8, 8'd7);
      check("w8 last", last8, 8'd7);
      check("w8 min", min8, 8'd7);
      check("w8 max", max8, 8'd7);
      check("w8 wraps", wraps8, 8'd0);
      rpt_ready = 1'b1; tick(); rpt_ready = 1'b0;
      check("w8 valid drops", {7'd0, valid8}, 8'd0);

      // Reset asserted between edges during a run clears outputs with no clock edge.
      start4 = 1'b1; result = 8'd9; tick();
      start4 = 1'b0; result = 8'd8; tick();
      result = 8'd7; tick();
      #2 rst = 1'b0;
      #1;
      check("async rst busy", {7'd0, busy4}, 8'd0);
      check("async rst valid", {7'd0, valid4}, 8'd0);
      check("async rst first4", first4, 8'd0);
      check("async rst last4", last4, 8'd0);
      check("async rst wraps4", wraps4, 8'd0);
      check("async rst max8", max8, 8'd0);
      check("async rst min8", min8, 8'd0);
      #2 rst = 1'b1;

      // Full window after release: strictly increasing gives three wraps.
      start4 = 1'b1; result = 8'd1; tick();
      start4 = 1'b0;
      check("post rst busy", {7'd0, busy4}, 8'd1);
      result = 8'd2; tick();
      result = 8'd3; tick();
      result = 8'd4; tick();
      check("post rst valid", {7'd0, valid4}, 8'd1);
      check("post rst first", first4, 8'd1);
      check("post rst last", last4, 8'd4);
      check("post rst min", min4, 8'd1);
      check("post rst max", max4, 8'd4);
      check("post rst wraps", wraps4, 8'd3);
      rpt_ready = 1'b1; tick(); rpt_ready = 1'b0;
      check("post rst valid drops", {7'd0, valid4}, 8'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/subtractor_result_monitor.md
# subtractor_result_monitor

Downstream observer for the feedback subtractor. It samples the subtractor's 8-bit `result` stream over a programmable window of consecutive cycles and tracks first, last, minimum and maximum values. It also counts wrap-around events, where the running difference steps upward because it underflowed past zero. At the end of each window it presents one summary report on a valid/ready port, for a host or a later ALU stage to consume.

## Interface
- `WINDOW`, default 16: samples per window, legal range 2..255.
- `clk`  in  1  rising-edge clock, shared with the subtractor.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `start`  in  1  level sampled in IDLE; begins a window.
- `abort`  in  1  abandons any window or pending report; has priority over `start`.
- `result`  in  8  subtractor output, unsigned.
- `busy`  out  1  high while in RUN.
- `rpt_valid`  out  1  report available.
- `rpt_ready`  in  1  consumer accepts report.
- `rpt_first`  out  8  first sample of the window.
- `rpt_last`  out  8  last sample of the window.
- `rpt_min`  out  8  unsigned minimum of the window.
- `rpt_max`  out  8  unsigned maximum of the window.
- `rpt_wraps`  out  8  count of wrap events in the window.

## Operation
- FSM states are IDLE, RUN and REPORT. All outputs are registered.
- **IDLE**, on an edge with `start`=1 and `abort`=0:
  - capture `result` as sample 0: first=last=min=max=prev=`result`;
  - set wraps=0, cnt=1;
  - go to RUN.
- **RUN**, on each edge with `abort`=0:
  - capture `result` as sample cnt;
  - wrap event when `result` > prev, strict unsigned compare; equal values are not a wrap;
  - wraps += wrap event; min/max update unsigned; last=prev=`result`; cnt += 1;
  - when the captured sample is index WINDOW-1, go to REPORT and load the `rpt_*` fields in the same edge.
- **REPORT**:
  - `rpt_valid`=1; all `rpt_*` fields are held stable;
  - `start` is ignored;
  - an edge with `rpt_valid`&&`rpt_ready` returns to IDLE.
- **abort**: in RUN or REPORT, go to IDLE on the next edge. The window is discarded, no report is emitted, and the `rpt_*` fields keep their previous values.
- Wrap count cannot exceed WINDOW-1, which is at most 254, so no saturation logic is needed.
- **Reset**: `rst`=0 forces IDLE immediately, regardless of `clk`, and clears every output:
  - `busy`=0, `rpt_valid`=0;
  - `rpt_first`=`rpt_last`=`rpt_min`=`rpt_max`=`rpt_wraps`=0;
  - internal cnt and prev are also cleared.

## Timing
- Sample k (k = 0..WINDOW-1) is captured on edge E0+k, where E0 is the edge in IDLE that sees `start`=1.
- `busy`:
  - rises after E0;
  - falls after E0+WINDOW-1, in the same cycle that `rpt_valid` rises.
- Report latency is 0 cycles after the final capture: `rpt_valid` is high in the cycle following E0+WINDOW-1.
- Handshake:
  - a report transfers on the edge where `rpt_valid`=`rpt_ready`=1;
  - `rpt_valid` is low from the next cycle;
  - `rpt_ready` may be high early, giving exactly one cycle of `rpt_valid`;
  - `rpt_ready` has no effect outside REPORT.
- Throughput: the earliest next window starts on the edge after the transfer edge (IDLE with `start`=1). Minimum period is WINDOW+1 cycles.
- `start` and `abort` high on the same IDLE edge: remain in IDLE.
- `abort` on the final RUN edge (sample WINDOW-1): abort wins, and `rpt_valid` never rises.
- Reset released mid-cycle: the first active edge after release behaves as IDLE.

## Test plan
- WINDOW=4; reset, release; pulse `start` with `result` 100, 95, 90, 85 on E0..E3 → `rpt_valid` high after E3; first=100, last=85, min=85, max=100, wraps=0; `busy` high exactly 3 cycles.
- WINDOW=4; `result` 10, 5, 0, 251 → min=0, max=251, wraps=1, last=251. Then repeat with 3, 254, 249, 244 → wraps=1, min=3, max=254.
- Backpressure: hold `rpt_ready`=0 for 5 cycles after the report appears → `rpt_valid` stays 1 and all fields are unchanged. Drive `rpt_ready`=1 for one cycle → `rpt_valid`=0 next cycle; a new `start` on the following edge is accepted.
- Abort and priority:
  - `abort` on E2 of a WINDOW=4 run → IDLE; `rpt_valid` never rises; prior `rpt_*` values are unchanged.
  - `start`=`abort`=1 in IDLE → `busy` stays 0.
- Constant input: WINDOW=8, `result` held at 7 → min=max=first=last=7, wraps=0.
- Reset mid-RUN: drop `rst` between edges during sample 2 → `busy`, `rpt_valid` and all `rpt_*` fields go to 0 without a clock edge. After release, a full window completes normally.
